// File: rtl/rc_bit_generator_pkg.sv
// rtl/rc_bit_generator_pkg.sv - shared Keccak iota constants, FSM encoding and slice-position decode
package rc_bit_generator_pkg;

    localparam int          ROUNDS       = 24;
    localparam int          LANE         = 64;
    localparam logic [7:0]  RC_LFSR_SEED = 8'h01;
    localparam logic [7:0]  RC_LFSR_TAPS = 8'h71;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        STREAM = 2'd2
    } rc_state_e;

    // Only slices 2^j-1 carry an LFSR-derived bit; all others are zero.
    function automatic logic is_rc_pos(input logic [5:0] slice);
        return (slice & (slice + 6'd1)) == 6'd0;
    endfunction

endpackage

// File: rtl/rc_bit_generator_counter.sv
// rtl/rc_bit_generator_counter.sv - modulo-N up counter with clear, enable and terminal-count flag
module CounterModN #(
    parameter int N = 64,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         co
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = co ? '0 : q_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q  = q_q;
    assign co = (q_q == W'(N - 1));

endmodule

// File: rtl/rc_bit_generator_lfsr.sv
// rtl/rc_bit_generator_lfsr.sv - rc(t) LFSR x^8+x^6+x^5+x^4+1, clr loads the seed and wins over step
module rc_lfsr
    import rc_bit_generator_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       step,
    output logic       rc_out
);

    logic [7:0] s_q;
    logic [7:0] s_d;

    always_comb begin
        s_d = s_q;
        if (clr) begin
            s_d = RC_LFSR_SEED;
        end else if (step) begin
            s_d = {s_q[6:0], 1'b0} ^ ({8{s_q[7]}} & RC_LFSR_TAPS);
        end
    end

    always_ff @(posedge clk) begin
        s_q <= s_d;
    end

    assign rc_out = s_q[0];

endmodule

// File: rtl/rc_bit_generator.sv
// rtl/rc_bit_generator.sv - slice-serial Keccak iota RC bit producer; RC_LANE_OUT_EN adds the assembled rcLane output
module rc_bit_generator
    import rc_bit_generator_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  roundNum,
    input  logic        sliceEn,
    output logic        ready,
    output logic        rcValid,
    output logic        rcBit,
    output logic        sliceCo,
    output logic        err
`ifdef RC_LANE_OUT_EN
    ,
    output logic [63:0] rcLane
`endif
);

    localparam logic [4:0] ROUND_LIMIT = 5'(ROUNDS);
    localparam logic [4:0] LAST_ROUND  = 5'(ROUNDS - 1);

    rc_state_e  state_q, state_d;
    logic [4:0] round_q, round_d;
    logic [4:0] next_round_q, next_round_d;
    logic [7:0] seek_cnt_q, seek_cnt_d;
    logic       ready_q, ready_d;
    logic       valid_q, valid_d;
    logic       slice_co_q, slice_co_d;
    logic       err_q, err_d;

    logic       lfsr_clr, lfsr_step, lfsr_bit;
    logic       cnt_en, cnt_co, rc_pos, lane_clr, consume;
    logic [5:0] slice;

    rc_lfsr u_lfsr (
        .clk    (clk),
        .clr    (lfsr_clr),
        .step   (lfsr_step),
        .rc_out (lfsr_bit)
    );

    CounterModN #(.N(LANE)) u_slice_cnt (
        .clk (clk),
        .clr (rst),
        .en  (cnt_en),
        .q   (slice),
        .co  (cnt_co)
    );

    assign rc_pos  = is_rc_pos(slice);
    assign rcBit   = (state_q == STREAM) && rc_pos && lfsr_bit;
    assign consume = (state_q == STREAM) && sliceEn;

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        next_round_d = next_round_q;
        seek_cnt_d   = seek_cnt_q;
        slice_co_d   = 1'b0;
        err_d        = 1'b0;
        lfsr_clr     = rst;
        lfsr_step    = 1'b0;
        cnt_en       = 1'b0;
        lane_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (roundNum >= ROUND_LIMIT) begin
                        err_d = 1'b1;
                    end else begin
                        round_d  = roundNum;
                        lane_clr = 1'b1;
                        if (roundNum == next_round_q) begin
                            state_d = STREAM;
                        end else begin
                            // Out-of-order round: rewind to t=0 and fast-forward 7 steps per round.
                            lfsr_clr   = 1'b1;
                            seek_cnt_d = 8'd7 * {3'b000, roundNum};
                            state_d    = (roundNum == 5'd0) ? STREAM : SEEK;
                        end
                    end
                end
            end
            SEEK: begin
                lfsr_step  = 1'b1;
                seek_cnt_d = seek_cnt_q - 8'd1;
                if (seek_cnt_q == 8'd1) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (sliceEn) begin
                    cnt_en    = 1'b1;
                    lfsr_step = rc_pos;
                    if (cnt_co) begin
                        state_d    = IDLE;
                        slice_co_d = 1'b1;
                        if (round_q == LAST_ROUND) begin
                            next_round_d = 5'd0;
                            lfsr_clr     = 1'b1;
                        end else begin
                            next_round_d = round_q + 5'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_d == STREAM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            round_q      <= '0;
            next_round_q <= '0;
            seek_cnt_q   <= '0;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            slice_co_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            next_round_q <= next_round_d;
            seek_cnt_q   <= seek_cnt_d;
            ready_q      <= ready_d;
            valid_q      <= valid_d;
            slice_co_q   <= slice_co_d;
            err_q        <= err_d;
        end
    end

    assign ready   = ready_q;
    assign rcValid = valid_q;
    assign sliceCo = slice_co_q;
    assign err     = err_q;

`ifdef RC_LANE_OUT_EN
    logic [63:0] lane_q, lane_d;

    always_comb begin
        lane_d = lane_q;
        if (lane_clr) begin
            lane_d = '0;
        end else if (consume) begin
            lane_d[slice] = rcBit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    assign rcLane = lane_q;
`else
    logic unused_lane;
    assign unused_lane = lane_clr ^ consume;
`endif

endmodule
